button_debouncer: RTL

//   Cleans one raw, asynchronous push-button input (Zybo Z7-10 BTNx, 125 MHz clk) into a

---
 rtl/board_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/button_debouncer.sv | 114 +++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared board-level types and timing constants for the Zybo Z7-10 button path.
package board_pkg;

  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} db_state_t;

  localparam int CLK_HZ    = 125_000_000;
  localparam int DB_MS     = 10;
  localparam int REPEAT_MS = 500;

  function automatic int ms_to_cycles(input int ms);
    return int'((longint'(CLK_HZ) * longint'(ms)) / 64'sd1000);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DB_CYCLES_DFLT     = ms_to_cycles(DB_MS);
  localparam int REPEAT_CYCLES_DFLT = ms_to_cycles(REPEAT_MS);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit, reset to 0.
// Latency: 2 cycles. No backpressure.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces one push-button into a level plus press/release strobes; BTN_AUTOREPEAT_EN adds held-key repeat.
// Latency: DB_CYCLES+3 cycles from a stable raw edge to strobe. No backpressure; strobes are fire-and-forget.
module button_debouncer
  import board_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_DFLT,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DFLT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CNT_W = $clog2(max2(DB_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             s;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, press_nxt, release_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE_LO;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
    end
  end

  // cnt only advances below its compare value, so it can never wrap.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE_LO: begin
        if (s) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE_HI;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (cnt == REPEAT_LAST) begin
          press_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
`endif
      end
      WAIT_LO: begin
        // A rejected release glitch restarts the repeat period from zero.
        if (s) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt   = IDLE_LO;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
